// File: rtl/char_ram_if.sv
// Bus bundle between the character-RAM arbiter and its surroundings:
// the VGA fetch inputs, the CPU/clear requests, the RAM port and the status outputs.
interface char_ram_if #(
    parameter int AW = 15,
    parameter int DW = 16
);
    logic          vidon;
    logic [AW-1:0] vga_addr;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          clr_req;
    logic [DW-1:0] clr_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic          q_full;
    logic          busy;
    logic [7:0]    drop_cnt;

    modport master (
        output vidon, vga_addr, cpu_we, cpu_addr, cpu_data, clr_req, clr_data,
        input  ram_addr, ram_din, ram_we, q_full, busy, drop_cnt
    );

    modport slave (
        input  vidon, vga_addr, cpu_we, cpu_addr, cpu_data, clr_req, clr_data,
        output ram_addr, ram_din, ram_we, q_full, busy, drop_cnt
    );
endinterface

// File: rtl/char_ram_arbiter.sv
// Single-port character RAM arbiter: VGA fetches own the RAM during active video,
// queued CPU writes and a hardware screen-clear retire only during blanking.
module char_ram_arbiter #(
    parameter int AW        = 15,
    parameter int DW        = 16,
    parameter int QDEPTH    = 4,
    parameter int CLR_WORDS = 4800
) (
    input  logic     clk,
    input  logic     rst,
    char_ram_if.slave bus
);

    localparam int QW = $clog2(QDEPTH);
    localparam int CW = QW + 1;
    localparam int PW = $clog2(CLR_WORDS);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    state_e        state_q, state_d;
    logic [QW-1:0] rd_ptr_q, rd_ptr_d;
    logic [QW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] clr_ptr_q, clr_ptr_d;
    logic [DW-1:0] fill_q, fill_d;
    logic          q_full_q, q_full_d;
    logic          busy_q, busy_d;
    logic [7:0]    drop_q, drop_d;
    entry_t        mem_q [QDEPTH];
    entry_t        head;

    logic push, pop, clr_accept, clr_step, clr_last;

    // NOTE: combinational blocks use blocking '=' and give every output a default
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        push       = bus.cpu_we && !q_full_q;
        pop        = !bus.vidon && (state_q == DRAIN);
        clr_accept = bus.clr_req && (state_q != CLEAR);
        clr_step   = !bus.vidon && (state_q == CLEAR);
        clr_last   = clr_step && (clr_ptr_q == PW'(CLR_WORDS - 1));

        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        fill_d    = fill_q;
        rd_ptr_d  = pop  ? rd_ptr_q + QW'(1) : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + QW'(1) : wr_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);

        if (clr_step) begin
            clr_ptr_d = clr_last ? '0 : clr_ptr_q + PW'(1);
        end

        // A new clear restarts from address 0; queued writes wait until it finishes.
        if (clr_accept) begin
            state_d   = CLEAR;
            clr_ptr_d = '0;
            fill_d    = bus.clr_data;
        end else if ((state_q == CLEAR) && !clr_last) begin
            state_d = CLEAR;
        end else begin
            state_d = (count_d != '0) ? DRAIN : IDLE;
        end

        q_full_d = (count_d == CW'(QDEPTH));
        busy_d   = (count_d != '0) || (state_d == CLEAR);
        drop_d   = (bus.cpu_we && q_full_q && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    // RAM port mux: VGA has zero added latency; blanking cycles carry one write.
    always_comb begin
        head         = mem_q[rd_ptr_q];
        bus.ram_addr = bus.vga_addr;
        bus.ram_din  = '0;
        bus.ram_we   = 1'b0;
        if (!bus.vidon) begin
            case (state_q)
                CLEAR: begin
                    bus.ram_addr = AW'(clr_ptr_q);
                    bus.ram_din  = fill_q;
                    bus.ram_we   = 1'b1;
                end
                DRAIN: begin
                    bus.ram_addr = head.addr;
                    bus.ram_din  = head.data;
                    bus.ram_we   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential blocks use non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            clr_ptr_q <= '0;
            fill_q    <= '0;
            q_full_q  <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            clr_ptr_q <= clr_ptr_d;
            fill_q    <= fill_d;
            q_full_q  <= q_full_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    // NOTE: queue storage has no reset; the reset pointers and occupancy make
    // any stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_t'{addr: bus.cpu_addr, data: bus.cpu_data};
        end
    end

    assign bus.q_full   = q_full_q;
    assign bus.busy     = busy_q;
    assign bus.drop_cnt = drop_q;

endmodule
